uart_cmd_sequencer: RTL and testbench
=====================================

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles each command is driven on cmd (legal 1..255).
REQ-002 Parameter GAP_CYCLES, default 16: cycles of 8'h00 forced after each command (legal 1..255).
REQ-003 Parameter DEPTH, fixed 4: command FIFO depth.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk only.
REQ-006 rx_data  input  8  byte from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data valid in the same cycle.
REQ-008 clear_ovf  input  1  clears the overflow flag.
REQ-009 cmd  output  8  command byte to the stats block; 8'h00 means no command.
REQ-010 cmd_active  output  1  high while cmd carries a non-zero command.
REQ-011 fifo_count  output  3  number of queued commands, 0..4.
REQ-012 overflow  output  1  sticky; an accepted byte was dropped because the FIFO was full.
REQ-013 rejected  output  1  one-cycle pulse; rx byte was not a legal command.

Function
REQ-014 Legal commands are 8'h65 'e', 8'h73 's', 8'h70 'p', 8'h63 'c', 8'h77 'w'; matching is exact 8-bit compare.
REQ-015 Cycle with rx_valid=1 and legal rx_data: byte is written to the FIFO tail at that edge, unless REQ-019 applies.
REQ-016 Cycle with rx_valid=1 and illegal rx_data: byte discarded; rejected=1 in the following cycle only; FIFO unchanged.
REQ-017 rx_valid=0: rx_data ignored; no push, no rejected pulse.
REQ-018 FIFO is circular: 2-bit read/write pointers wrap 3->0; fifo_count = pushes minus pops, never exceeds 4 or underflows.
REQ-019 Full FIFO (count=4), legal push, no pop in the same cycle: byte dropped, overflow set to 1 at that edge, FIFO contents unchanged.
REQ-020 Full FIFO with push and pop in the same cycle: both occur, count stays 4, overflow not set.
REQ-021 overflow holds until clear_ovf=1 is sampled; clear has priority over a same-cycle set.
REQ-022 FSM states: IDLE, HOLD, GAP.
REQ-023 IDLE: cmd=8'h00, cmd_active=0; if fifo_count>0, pop head at the edge, load cmd with head byte, load counter HOLD_CYCLES-1, go to HOLD.
REQ-024 HOLD: cmd=held byte, cmd_active=1 for exactly HOLD_CYCLES cycles; when counter=0, load GAP_CYCLES-1, go to GAP with cmd=8'h00.
REQ-025 GAP: cmd=8'h00, cmd_active=0 for exactly GAP_CYCLES cycles; when counter=0, go to IDLE.
REQ-026 Latency: legal byte with rx_valid at edge N into an empty FIFO with FSM in IDLE -> cmd shows byte after edge N+1, i.e. 2 cycles after the strobe.
REQ-027 Back-to-back queued commands: each separated by GAP_CYCLES cycles of 8'h00 plus 1 IDLE cycle; never two non-zero commands adjacent.
REQ-028 A push arriving during HOLD or GAP is queued and does not alter the current cmd.
REQ-029 Counter is 8 bits; no wrap beyond its loaded value.
REQ-030 cmd, cmd_active, rejected and overflow are registered outputs, glitch-free.

Reset
REQ-031 reset=0 at a rising edge: FSM->IDLE, counters->0, pointers->0, fifo_count=0, cmd=8'h00, cmd_active=0, overflow=0, rejected=0.
REQ-032 Reset mid-HOLD or mid-GAP aborts the command; cmd=8'h00 from the next cycle; queued bytes are discarded.
REQ-033 rx_valid while reset=0: ignored.

Verification
REQ-034 Single 'e': rx 8'h65 at edge N -> cmd=8'h65 for cycles N+2..N+17, then 8'h00; cmd_active mirrors.
REQ-035 Illegal byte 8'h41 -> rejected pulse for 1 cycle; fifo_count stays 0; cmd stays 8'h00.
REQ-036 Burst of 6 legal bytes on consecutive cycles, FSM idle -> first popped, 4 queued, sixth dropped, overflow=1; clear_ovf -> overflow=0.
REQ-037 Two queued commands 'e','s' -> 8'h65 for 16 cycles, 8'h00 for 17 cycles, 8'h73 for 16 cycles.
REQ-038 Push and pop in the same cycle at count=4 -> count stays 4, overflow stays 0.
REQ-039 reset low during HOLD with 3 queued -> next cycle cmd=8'h00, fifo_count=0; no further commands emitted.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// Queues legal UART command bytes in a 4-entry FIFO and replays each on cmd for HOLD_CYCLES,
// followed by GAP_CYCLES of 8'h00, so the downstream stats block never sees adjacent commands.
module uart_cmd_sequencer #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned DEPTH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       clear_ovf,
   output logic [7:0] cmd,
   output logic       cmd_active,
   output logic [2:0] fifo_count,
   output logic       overflow,
   output logic       rejected
);

   typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

   localparam logic [7:0] HoldLoad  = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GapLoad   = 8'(GAP_CYCLES - 1);
   localparam logic [2:0] FullCount = 3'(DEPTH);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cmd_q, cmd_d;
   logic       act_q, act_d;
   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic       rej_q, rej_d;

   logic legal, full, push, pop;

   always_comb begin
      legal = rx_data inside {8'h65, 8'h73, 8'h70, 8'h63, 8'h77};
      full  = (count_q == FullCount);
      pop   = (state_q == StIdle) && (count_q != 3'd0);
      // A full FIFO still accepts a byte when the head leaves on the same edge.
      push  = rx_valid && legal && (!full || pop);

      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      act_d    = act_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;

      if (push) begin
         mem_d[wr_ptr_q] = rx_data;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + 3'(push) - 3'(pop);

      rej_d = rx_valid && !legal;

      if (clear_ovf) begin
         ovf_d = 1'b0;
      end else if (rx_valid && legal && full && !pop) begin
         ovf_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = StHold;
               cmd_d   = mem_q[rd_ptr_q];
               act_d   = 1'b1;
               cnt_d   = HoldLoad;
            end
         end
         StHold: begin
            if (cnt_q == 8'd0) begin
               state_d = StGap;
               cmd_d   = 8'h00;
               act_d   = 1'b0;
               cnt_d   = GapLoad;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StGap: begin
            if (cnt_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cmd_d   = 8'h00;
            act_d   = 1'b0;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= 8'd0;
         cmd_q    <= 8'h00;
         act_q    <= 1'b0;
         mem_q    <= '{default: 8'h00};
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         act_q    <= act_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         rej_q    <= rej_d;
      end
   end

   assign cmd        = cmd_q;
   assign cmd_active = act_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;
   assign rejected   = rej_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: directed scenarios plus random traffic, all checked against a
// timeline model (byte queue + per-command start/end edge numbers).
module tb_uart_cmd_sequencer;

   localparam int H = 16;
   localparam int G = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       clear_ovf;
   logic [7:0] cmd;
   logic       cmd_active;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       rejected;

   always #5 clk = ~clk;

   uart_cmd_sequencer #(
      .HOLD_CYCLES(H),
      .GAP_CYCLES (G),
      .DEPTH      (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .clear_ovf (clear_ovf),
      .cmd       (cmd),
      .cmd_active(cmd_active),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .rejected  (rejected)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: te is the index of the next rising edge.
   int         te        = 0;
   logic [7:0] mq[$];
   int         next_pop  = 0;
   int         cmd_start = 0;
   int         cmd_end   = 0;
   logic [7:0] cur       = 8'h00;
   logic       m_ovf     = 1'b0;
   logic       m_rej     = 1'b0;
   logic [7:0] exp_cmd;
   logic       exp_act;
   logic [2:0] exp_cnt;
   logic [7:0] legal_tab [5] = '{8'h65, 8'h73, 8'h70, 8'h63, 8'h77};

   function automatic logic is_cmd(input logic [7:0] b);
      return b inside {8'h65, 8'h73, 8'h70, 8'h63, 8'h77};
   endfunction

   task automatic step(input logic v, input logic [7:0] d, input logic clr, input logic rst);
      logic       do_pop;
      logic [7:0] head;
      int         sz;
      reset     = rst;
      rx_valid  = v;
      rx_data   = d;
      clear_ovf = clr;
      @(posedge clk);
      if (!rst) begin
         mq.delete();
         next_pop = te + 1;
         cmd_end  = te;
         m_ovf    = 1'b0;
         m_rej    = 1'b0;
      end else begin
         sz     = mq.size();
         do_pop = (sz > 0) && (te >= next_pop);
         if (do_pop) begin
            head      = mq.pop_front();
            cur       = head;
            cmd_start = te;
            cmd_end   = te + H;
            next_pop  = te + H + G + 1;
         end
         m_rej = v && !is_cmd(d);
         if (v && is_cmd(d)) begin
            if (sz == 4 && !do_pop) m_ovf = 1'b1;
            else mq.push_back(d);
         end
         if (clr) m_ovf = 1'b0;
      end
      exp_act = (te >= cmd_start) && (te < cmd_end);
      exp_cmd = exp_act ? cur : 8'h00;
      exp_cnt = 3'(mq.size());
      te++;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'($urandom), 1'b0, 1'b1);
   endtask

   task automatic drain();
      int k = 0;
      while ((mq.size() != 0 || te < next_pop) && k < 400) begin
         idle();
         k++;
      end
   endtask

   task automatic test_reset();
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h65, 1'b0, 1'b0);
      n_checks++;
      if (cmd !== 8'h00) $display("FAIL reset_cmd: got %h want 00", cmd);
      else n_pass++;
      n_checks++;
      if (cmd_active !== 1'b0) $display("FAIL reset_act: got %b want 0", cmd_active);
      else n_pass++;
      n_checks++;
      if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0 || rejected !== 1'b0)
         $display("FAIL reset_flags: got ovf=%b rej=%b want 0 0", overflow, rejected);
      else n_pass++;
      idle();
      n_checks++;
      if (fifo_count !== 3'd0 || cmd !== 8'h00)
         $display("FAIL reset_rx_ignored: got count=%0d cmd=%h want 0 00", fifo_count, cmd);
      else n_pass++;
   endtask

   task automatic test_single_cmd();
      int first = -1;
      int len   = 0;
      drain();
      step(1'b1, 8'h65, 1'b0, 1'b1);
      n_checks++;
      if (cmd !== 8'h00) $display("FAIL single_latency: got %h want 00 after strobe", cmd);
      else n_pass++;
      for (int i = 0; i < 40; i++) begin
         idle();
         n_checks++;
         if (cmd !== exp_cmd || cmd_active !== exp_act)
            $display("FAIL single_trace: cyc %0d got %h/%b want %h/%b",
                     i, cmd, cmd_active, exp_cmd, exp_act);
         else n_pass++;
         if (cmd == 8'h65) begin
            if (first < 0) first = i;
            len++;
         end
      end
      n_checks++;
      if (first !== 0 || len !== H)
         $display("FAIL single_window: got first=%0d len=%0d want 0 %0d", first, len, H);
      else n_pass++;
   endtask

   task automatic test_reject();
      drain();
      step(1'b1, 8'h41, 1'b0, 1'b1);
      n_checks++;
      if (rejected !== 1'b1 || fifo_count !== 3'd0 || cmd !== 8'h00)
         $display("FAIL reject_pulse: got rej=%b count=%0d cmd=%h want 1 0 00",
                  rejected, fifo_count, cmd);
      else n_pass++;
      idle();
      n_checks++;
      if (rejected !== 1'b0 || cmd !== 8'h00)
         $display("FAIL reject_one_cycle: got rej=%b cmd=%h want 0 00", rejected, cmd);
      else n_pass++;
   endtask

   task automatic test_overflow_burst();
      drain();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, legal_tab[i % 5], 1'b0, 1'b1);
         n_checks++;
         if (fifo_count !== exp_cnt)
            $display("FAIL burst_count: byte %0d got %0d want %0d", i, fifo_count, exp_cnt);
         else n_pass++;
      end
      n_checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1)
         $display("FAIL burst_overflow: got count=%0d ovf=%b want 4 1", fifo_count, overflow);
      else n_pass++;
      idle();
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
      else n_pass++;
      step(1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] trace [70];
      int         run [3];
      int         seg = 0;
      drain();
      step(1'b1, 8'h65, 1'b0, 1'b1);
      for (int i = 0; i < 70; i++) begin
         if (i == 0) step(1'b1, 8'h73, 1'b0, 1'b1);
         else idle();
         trace[i] = cmd;
         n_checks++;
         if (cmd !== exp_cmd)
            $display("FAIL b2b_trace: cyc %0d got %h want %h", i, cmd, exp_cmd);
         else n_pass++;
      end
      run = '{0, 0, 0};
      for (int i = 0; i < 70; i++) begin
         if (seg == 0 && trace[i] != 8'h65) seg = 1;
         if (seg == 1 && trace[i] != 8'h00) seg = 2;
         if (seg == 2 && trace[i] != 8'h73) break;
         run[seg]++;
      end
      n_checks++;
      if (run[0] !== H || run[1] !== G + 1 || run[2] !== H)
         $display("FAIL b2b_runs: got %0d/%0d/%0d want %0d/%0d/%0d",
                  run[0], run[1], run[2], H, G + 1, H);
      else n_pass++;
   endtask

   task automatic test_push_pop_full();
      int k = 0;
      drain();
      for (int i = 0; i < 5; i++) step(1'b1, legal_tab[i], 1'b0, 1'b1);
      while (te < next_pop && k < 200) begin
         idle();
         k++;
      end
      n_checks++;
      if (fifo_count !== 3'd4) $display("FAIL full_setup: got %0d want 4", fifo_count);
      else n_pass++;
      step(1'b1, 8'h77, 1'b0, 1'b1);
      n_checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0)
         $display("FAIL push_pop_full: got count=%0d ovf=%b want 4 0", fifo_count, overflow);
      else n_pass++;
      n_checks++;
      if (cmd !== exp_cmd || cmd_active !== 1'b1)
         $display("FAIL push_pop_cmd: got %h/%b want %h/1", cmd, cmd_active, exp_cmd);
      else n_pass++;
   endtask

   task automatic test_reset_mid_hold();
      int nz = 0;
      for (int i = 0; i < 5; i++) idle();
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (cmd !== 8'h00 || cmd_active !== 1'b0 || fifo_count !== 3'd0)
         $display("FAIL reset_abort: got cmd=%h act=%b count=%0d want 00 0 0",
                  cmd, cmd_active, fifo_count);
      else n_pass++;
      for (int i = 0; i < 80; i++) begin
         idle();
         if (cmd != 8'h00) nz++;
      end
      n_checks++;
      if (nz !== 0) $display("FAIL reset_flush: got %0d non-zero cmd cycles want 0", nz);
      else n_pass++;
   endtask

   task automatic test_random();
      logic       v, clr, rst;
      logic [7:0] d;
      for (int i = 0; i < 2000; i++) begin
         v   = ($urandom_range(0, 1) == 1);
         d   = ($urandom_range(0, 9) < 7) ? legal_tab[$urandom_range(0, 4)] : 8'($urandom);
         clr = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 199) != 0);
         step(v, d, clr, rst);
         n_checks++;
         if (cmd !== exp_cmd || cmd_active !== exp_act || fifo_count !== exp_cnt ||
             overflow !== m_ovf || rejected !== m_rej)
            $display("FAIL random: cyc %0d got %h/%b/%0d/%b/%b want %h/%b/%0d/%b/%b", i,
                     cmd, cmd_active, fifo_count, overflow, rejected,
                     exp_cmd, exp_act, exp_cnt, m_ovf, m_rej);
         else n_pass++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_cmd();
      test_reject();
      test_overflow_burst();
      test_back_to_back();
      test_push_pop_full();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
